wb_trace_fifo: RTL and testbench

// - Write-back trace capture for the pipelined MIPS core: receives every GRF write
//   (PC, register number, data) from the W stage and buffers it in a FIFO.
// - A consumer drains entries in order over a valid/ready interface: a simulation

---
 rtl/wb_trace_fifo_pkg.sv | 13 +
 rtl/wb_trace_fifo_if.sv | 25 ++
 rtl/wb_trace_fifo_sync_fifo.sv | 63 ++++++
 rtl/wb_trace_fifo.sv | 75 +++++++
 tb/tb_wb_trace_fifo.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_fifo_pkg.sv
// Shared definitions for the write-back trace stream: record width and field
// positions, so every trace producer and consumer agrees on the layout.
package wb_trace_fifo_pkg;

  localparam int TRACE_W  = 69;
  localparam int PC_MSB   = 68;
  localparam int PC_LSB   = 37;
  localparam int ADDR_MSB = 36;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/wb_trace_fifo_if.sv
// W-stage register-write tap plus the valid/ready drain port of the trace FIFO.
interface wb_trace_fifo_if;

  logic        wb_we;
  logic [31:0] wb_pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_data;

  modport master (
    output wb_we, wb_pc, wb_addr, wb_data, out_ready,
    input  out_valid, out_pc, out_addr, out_data
  );

  modport slave (
    input  wb_we, wb_pc, wb_addr, wb_data, out_ready,
    output out_valid, out_pc, out_addr, out_data
  );

endinterface

// File: rtl/wb_trace_fifo_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// The caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/wb_trace_fifo.sv
// Write-back trace capture: filters $0 writes, buffers GRF writes in a FWFT FIFO,
// and accounts for entries lost while the FIFO is full.
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter bit FILTER_ZERO = 1'b1,
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_trace_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  logic               cap, push, pop, full, empty;
  logic [TRACE_W-1:0] wdata, head;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign cap  = bus.wb_we & ~(FILTER_ZERO & (bus.wb_addr == 5'd0));
  assign pop  = ~empty & bus.out_ready;
  assign push = cap & (~full | pop);

  assign wdata[PC_MSB:PC_LSB]     = bus.wb_pc;
  assign wdata[ADDR_MSB:ADDR_LSB] = bus.wb_addr;
  assign wdata[DATA_MSB:DATA_LSB] = bus.wb_data;

  sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A capture that finds the FIFO full with no simultaneous pop is lost.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (cap & full & ~pop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Stale storage never leaks onto the port while nothing is queued.
  assign bus.out_valid = ~empty;
  assign bus.out_pc    = empty ? '0 : head[PC_MSB:PC_LSB];
  assign bus.out_addr  = empty ? '0 : head[ADDR_MSB:ADDR_LSB];
  assign bus.out_data  = empty ? '0 : head[DATA_MSB:DATA_LSB];

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized bench for wb_trace_fifo: stimulus pushes expected entries into a
// scoreboard, a negedge monitor pops and compares whatever the DUT drains.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b0;

  logic [4:0]  count, count2;
  logic        overflow, overflow2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;

  wb_trace_fifo_if bus ();
  wb_trace_fifo_if bus2 ();

  assign bus.wb_we      = wb_we;
  assign bus.wb_pc      = wb_pc;
  assign bus.wb_addr    = wb_addr;
  assign bus.wb_data    = wb_data;
  assign bus.out_ready  = out_ready;
  assign bus2.wb_we     = wb_we;
  assign bus2.wb_pc     = wb_pc;
  assign bus2.wb_addr   = wb_addr;
  assign bus2.wb_data   = wb_data;
  assign bus2.out_ready = out_ready;

  wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_ZERO(1'b1), .DROP_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // Narrow drop counter instance, used to observe saturation.
  wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_ZERO(1'b1), .DROP_W(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus2),
    .count    (count2),
    .overflow (overflow2),
    .drop_cnt (drop_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   m_cnt   = 0;
  bit   m_ovf   = 1'b0;
  int   m_drop  = 0;
  int   m_drop2 = 0;
  logic [31:0] last_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus (called just after a posedge) and advance the model.
  task automatic step(input logic we, input logic [31:0] pc, input logic [4:0] addr,
                      input logic [31:0] data, input logic rdy);
    bit cap, pop, push;
    wb_we = we; wb_pc = pc; wb_addr = addr; wb_data = data; out_ready = rdy;
    cap  = we && (addr != 5'd0);
    pop  = (m_cnt > 0) && rdy;
    push = cap && ((m_cnt < DEPTH) || pop);
    if (push) sb.push_back('{pc: pc, addr: addr, data: data});
    if (cap && !push) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
      if (m_drop2 < 3) m_drop2++;
    end
    m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    wb_we = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; wb_we = 1'b0; out_ready = 1'b0;
    sb.delete();
    m_cnt = 0; m_ovf = 1'b0; m_drop = 0; m_drop2 = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"},     count,         m_cnt);
    check({tag, ".valid"},     bus.out_valid, m_cnt != 0);
    check({tag, ".overflow"},  overflow,      m_ovf);
    check({tag, ".drop"},      drop_cnt,      m_drop);
    check({tag, ".overflow2"}, overflow2,     m_ovf);
    check({tag, ".drop2"},     drop_cnt2,     m_drop2);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom, 5'($urandom_range(1, 31)), 32'(base + i), 1'b0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && m_cnt > 0; i++) step(1'b0, '0, '0, '0, 1'b1);
    check("drain.empty", m_cnt == 0, 1'b1);
  endtask

  // Monitor: compares each accepted head entry against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            check("mon.unexpected_pop", 1'b1, 1'b0);
          end else begin
            ent_t e;
            e = sb.pop_front();
            check("mon.pc",   bus.out_pc,   e.pc);
            check("mon.addr", bus.out_addr, e.addr);
            check("mon.data", bus.out_data, e.data);
            last_data = bus.out_data;
          end
        end
      end else begin
        check("mon.idle_zero", {bus.out_pc, bus.out_addr, bus.out_data}, '0);
      end
    end
  end

  initial begin
    do_reset();
    check_status("reset");

    // Single write appears one cycle later.
    step(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0);
    check("first.valid", bus.out_valid, 1'b1);
    check("first.pc",    bus.out_pc,    32'h3000);
    check("first.addr",  bus.out_addr,  5'd8);
    check("first.data",  bus.out_data,  32'h1234);
    check("first.count", count,         5'd1);
    drain(4);

    // Writes to $0 are filtered.
    step(1'b1, 32'h3004, 5'd0, 32'h5555, 1'b0);
    check("zero.count", count,         5'd0);
    check("zero.valid", bus.out_valid, 1'b0);
    check("zero.drop",  drop_cnt,      16'd0);

    // Fill, overflow by one, drain in order.
    do_reset();
    push_n(16, 1);
    check("full.count", count, 5'd16);
    step(1'b1, 32'h4000, 5'd3, 32'd17, 1'b0);
    check("ovf.count", count,    5'd16);
    check("ovf.flag",  overflow, 1'b1);
    check("ovf.drop",  drop_cnt, 16'd1);
    drain(20);
    check("ovf.last", last_data, 32'd16);

    // Full with simultaneous push and pop.
    push_n(16, 100);
    step(1'b1, 32'h5000, 5'd9, 32'hAA, 1'b1);
    check("fullpop.count", count,    5'd16);
    check("fullpop.drop",  drop_cnt, 16'd1);
    drain(20);
    check("fullpop.last", last_data, 32'hAA);
    check_status("fullpop");

    // Reset with entries queued.
    push_n(5, 200);
    do_reset();
    check_status("midreset");
    check("midreset.out", {bus.out_pc, bus.out_addr, bus.out_data}, '0);

    // Drop counter saturation on the narrow instance.
    push_n(16, 300);
    push_n(4, 400);
    check("sat.drop2", drop_cnt2, 2'd3);
    check("sat.drop",  drop_cnt,  16'd4);
    check_status("sat");
    drain(20);

    // Pointer wrap: concurrent push/pop for 40 cycles.
    do_reset();
    for (int i = 0; i < 40; i++)
      step(1'b1, $urandom, 5'($urandom_range(1, 31)), 32'(1000 + i), 1'b1);
    check_status("wrap");
    drain(20);

    // Random traffic, including $0 writes, fills and drops.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, 5'($urandom_range(0, 31)), $urandom,
           ($urandom % 3) == 0);
      check_status("rand");
    end
    drain(40);
    check("final.sb_empty", sb.size(), 0);
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
